tiny_dnn_seq: RTL

Control sequencer directly upstream of tiny_dnn_core and normalize. It streams one weight vector plus an optional bias into the core's weight RAM. For each dot product it issues init, the exec address sweep and the bias cycle. It then waits out the three-stage core/fma pipeline, pulses normalize's en, and flags when the fp32 result is valid.

---
 rtl/tiny_dnn_seq_if.sv | 33 +++
 rtl/tiny_dnn_seq.sv | 135 +++++++++++++
 2 files changed

// File: rtl/tiny_dnn_seq_if.sv
// rtl/tiny_dnn_seq_if.sv - control and weight-stream bundle between the host side and tiny_dnn_seq
interface tiny_dnn_seq_if #(
  parameter int AW = 10
);
  logic          load;
  logic          run;
  logic [AW-1:0] vec_len;
  logic          use_bias;
  logic          wvalid;
  logic [15:0]   wdata;
  logic          wready;
  logic          write;
  logic          bwrite;
  logic [AW-1:0] wa;
  logic [15:0]   wd;
  logic          init;
  logic          exec;
  logic          bias;
  logic [AW-1:0] ra;
  logic          norm_en;
  logic          out_valid;
  logic          busy;

  modport slave (
    input  load, run, vec_len, use_bias, wvalid, wdata,
    output wready, write, bwrite, wa, wd, init, exec, bias, ra, norm_en, out_valid, busy
  );

  modport master (
    output load, run, vec_len, use_bias, wvalid, wdata,
    input  wready, write, bwrite, wa, wd, init, exec, bias, ra, norm_en, out_valid, busy
  );
endinterface

// File: rtl/tiny_dnn_seq.sv
// rtl/tiny_dnn_seq.sv - weight-load and dot-product sequencer for tiny_dnn_core and normalize
module tiny_dnn_seq #(
  parameter int F_SIZE = 1024,
  parameter int AW     = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  tiny_dnn_seq_if.slave bus_if
);

  typedef enum logic [3:0] {
    IDLE, LOADW, LOADB, INIT, RUN, BIAS, DRAIN, NORM, DONE
  } state_t;

  localparam logic [AW-1:0] BIAS_ADDR = AW'(F_SIZE - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] len_q, len_d;
  logic          bias_q, bias_d;
  logic          drain_q, drain_d;
  logic [AW-1:0] len_in;

  // Term count is clamped so neither address sweep can land on the bias slot
  assign len_in = ({1'b0, bus_if.vec_len} >= (AW+1)'(F_SIZE - 1)) ? BIAS_ADDR : bus_if.vec_len;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      bias_q  <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      bias_q  <= bias_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    len_d            = len_q;
    bias_d           = bias_q;
    drain_d          = drain_q;
    bus_if.wready    = 1'b0;
    bus_if.write     = 1'b0;
    bus_if.bwrite    = 1'b0;
    bus_if.wa        = '0;
    bus_if.wd        = '0;
    bus_if.init      = 1'b0;
    bus_if.exec      = 1'b0;
    bus_if.bias      = 1'b0;
    bus_if.ra        = '0;
    bus_if.norm_en   = 1'b0;
    bus_if.out_valid = 1'b0;
    bus_if.busy      = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        cnt_d   = '0;
        drain_d = 1'b1;
        if (bus_if.load) begin
          len_d  = len_in;
          bias_d = bus_if.use_bias;
          if (len_in == '0) state_d = bus_if.use_bias ? LOADB : IDLE;
          else              state_d = LOADW;
        end else if (bus_if.run) begin
          len_d   = len_in;
          bias_d  = bus_if.use_bias;
          state_d = INIT;
        end
      end
      LOADW: begin
        bus_if.wready = 1'b1;
        bus_if.write  = bus_if.wvalid;
        bus_if.wa     = cnt_q;
        bus_if.wd     = bus_if.wdata;
        if (bus_if.wvalid) begin
          if (cnt_q == len_q - 1'b1) begin
            cnt_d   = '0;
            state_d = bias_q ? LOADB : IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LOADB: begin
        bus_if.wready = 1'b1;
        bus_if.write  = bus_if.wvalid;
        bus_if.bwrite = bus_if.wvalid;
        bus_if.wa     = BIAS_ADDR;
        bus_if.wd     = bus_if.wdata;
        if (bus_if.wvalid) state_d = IDLE;
      end
      INIT: begin
        bus_if.init = 1'b1;
        if (len_q == '0) state_d = bias_q ? BIAS : DRAIN;
        else             state_d = RUN;
      end
      RUN: begin
        bus_if.exec = 1'b1;
        bus_if.ra   = cnt_q;
        if (cnt_q == len_q - 1'b1) begin
          cnt_d   = '0;
          state_d = bias_q ? BIAS : DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BIAS: begin
        bus_if.bias = 1'b1;
        state_d     = DRAIN;
      end
      // Two cycles covering the core's exec2 stage and the adder settling
      DRAIN: begin
        if (drain_q == 1'b0) state_d = NORM;
        else                 drain_d = 1'b0;
      end
      NORM: begin
        bus_if.norm_en = 1'b1;
        state_d        = DONE;
      end
      DONE: begin
        bus_if.out_valid = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
